// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states and the stall-bus level constants.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldivOp_e;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    CALC,
    FIX,
    DONE
  } muldivState_e;

  // Stall-bus levels as seen by the pipeline stall controller
  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Signed ops are the ones with a clear low opcode bit
  function automatic logic opIsSigned(input muldivOp_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  // Divides are the ones with a set high opcode bit
  function automatic logic opIsDiv(input muldivOp_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step
// (LSB-first on the multiplier held in the low half of the accumulator)
// or a restoring-division step on {rem, quot}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_operand,
  input  logic               i_isDiv,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0] w_sum;
  logic [WIDTH:0] w_partial;
  logic [WIDTH:0] w_diff;
  logic           w_keep;

  // Multiply: add the multiplicand into the high half when the current
  // multiplier bit is set; the carry lands in bit WIDTH and is shifted down.
  assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
               + (i_acc[0] ? {1'b0, i_operand} : {(WIDTH+1){1'b0}});

  // Divide: remainder shifted left with the next dividend bit brought in.
  // The shifted remainder is below twice the divisor, so at WIDTH+1 bits
  // the top bit of the difference is a reliable borrow.
  assign w_partial = i_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_partial - {1'b0, i_operand};
  assign w_keep    = ~w_diff[WIDTH];

  // Select the next accumulator value for the active mode
  always_comb begin
    o_acc = '0;
    if (i_isDiv) begin
      o_acc = {(w_keep ? w_diff[WIDTH-1:0] : w_partial[WIDTH-1:0]),
               i_acc[WIDTH-2:0], w_keep};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_muldiv.sv
// Iterative signed/unsigned multiply/divide for the EX stage. One result
// bit per cycle; signs are stripped in PREP and reapplied in FIX so the
// core iteration is always unsigned.
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [1:0]         op_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               annul_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o,
  output logic               div_by_zero_o,
  output logic               stallreq_o
);

  localparam int CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  muldivState_e       r_state;
  muldivOp_e          r_op;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_operand;
  logic [2*WIDTH-1:0] r_acc;
  logic [CntW-1:0]    r_cnt;
  logic               r_negRes;
  logic               r_negRem;
  logic [2*WIDTH-1:0] r_result;
  logic               r_ready;
  logic               r_dbz;

  logic               w_signed;
  logic               w_isDiv;
  logic               w_sa;
  logic               w_sb;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH-1:0] w_stepAcc;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [2*WIDTH-1:0] w_fixed;

  assign w_signed = opIsSigned(r_op);
  assign w_isDiv  = opIsDiv(r_op);
  assign w_sa     = w_signed & r_opa[WIDTH-1];
  assign w_sb     = w_signed & r_opb[WIDTH-1];
  // MIN_INT negates to itself, which read unsigned is exactly its magnitude
  assign w_absA   = w_sa ? (~r_opa + 1'b1) : r_opa;
  assign w_absB   = w_sb ? (~r_opb + 1'b1) : r_opb;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .i_isDiv   (w_isDiv),
    .o_acc     (w_stepAcc)
  );

  assign w_quot = r_acc[WIDTH-1:0];
  assign w_rem  = r_acc[2*WIDTH-1:WIDTH];

  // Reapply signs: whole product for multiply, quotient and remainder
  // independently for divide
  always_comb begin
    w_fixed = '0;
    if (w_isDiv) begin
      w_fixed = {(r_negRem ? (~w_rem + 1'b1) : w_rem),
                 (r_negRes ? (~w_quot + 1'b1) : w_quot)};
    end else begin
      w_fixed = r_negRes ? (~r_acc + 1'b1) : r_acc;
    end
  end

  // Control FSM and datapath registers; annul aborts from any state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= OP_MULT;
      r_opa     <= '0;
      r_opb     <= '0;
      r_operand <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_negRes  <= 1'b0;
      r_negRem  <= 1'b0;
      r_result  <= '0;
      r_ready   <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      if (annul_i) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start_i) begin
              r_op    <= muldivOp_e'(op_i);
              r_opa   <= opa_i;
              r_opb   <= opb_i;
              r_dbz   <= 1'b0;
              r_state <= PREP;
            end
          end
          PREP: begin
            r_negRes <= w_sa ^ w_sb;
            r_negRem <= w_sa;
            r_cnt    <= '0;
            if (w_isDiv && (r_opb == '0)) begin
              r_result <= {r_opa, {WIDTH{1'b1}}};
              r_dbz    <= 1'b1;
              r_ready  <= 1'b1;
              r_state  <= DONE;
            end else if (w_isDiv) begin
              r_operand <= w_absB;
              r_acc     <= {{WIDTH{1'b0}}, w_absA};
              r_state   <= CALC;
            end else begin
              r_operand <= w_absA;
              r_acc     <= {{WIDTH{1'b0}}, w_absB};
              r_state   <= CALC;
            end
          end
          CALC: begin
            r_acc <= w_stepAcc;
            if (r_cnt == LastCnt) begin
              r_state <= FIX;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          FIX: begin
            r_result <= w_fixed;
            r_ready  <= 1'b1;
            r_state  <= DONE;
          end
          DONE: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  // Stall is combinational so EX freezes in the issue cycle; released in DONE
  always_comb begin
    stallreq_o = NoStop;
    case (r_state)
      IDLE:              stallreq_o = start_i ? Stop : NoStop;
      PREP, CALC, FIX:   stallreq_o = Stop;
      default:           stallreq_o = NoStop;
    endcase
  end

  assign busy_o        = (r_state != IDLE);
  assign ready_o       = r_ready;
  assign result_o      = r_result;
  assign div_by_zero_o = r_dbz;

endmodule

// File: tb/tb_iter_muldiv.sv
// Directed bench for iter_muldiv at WIDTH=32. Inputs change on the falling
// edge and outputs are sampled there, so "cycle N" is the Nth falling edge
// after the one where start_i was raised.
module tb_iter_muldiv;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic [1:0]    op_i;
  logic [W-1:0]  opa_i;
  logic [W-1:0]  opb_i;
  logic          annul_i;
  logic          busy_o;
  logic          ready_o;
  logic [2*W-1:0] result_o;
  logic          div_by_zero_o;
  logic          stallreq_o;

  int testsRun;
  int testsFailed;
  int lat;
  bit sawReady;

  iter_muldiv #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .op_i          (op_i),
    .opa_i         (opa_i),
    .opb_i         (opb_i),
    .annul_i       (annul_i),
    .busy_o        (busy_o),
    .ready_o       (ready_o),
    .result_o      (result_o),
    .div_by_zero_o (div_by_zero_o),
    .stallreq_o    (stallreq_o)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [2*W-1:0] observed,
                             input logic [2*W-1:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Raise start_i for one cycle (cycle 0) with the given operation
  task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b);
    @(negedge clk);
    start_i = 1'b1;
    op_i    = op;
    opa_i   = a;
    opb_i   = b;
  endtask

  // Issue an op and count cycles until ready_o; optionally re-raise start_i
  // with other operands at cycle injCycle. lat = -1 on timeout.
  task automatic runOp(input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int injCycle,
                       output int latency);
    applyStimulus(op, a, b);
    latency = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (ready_o) begin
        latency = c;
        break;
      end
      if (c == injCycle) begin
        start_i = 1'b1;
        op_i    = 2'b00;
        opa_i   = 32'd3;
        opb_i   = 32'd3;
      end
    end
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst     = 1'b1;
    start_i = 1'b0;
    op_i    = 2'b00;
    opa_i   = '0;
    opb_i   = '0;
    annul_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("rstBusy",   {63'd0, busy_o},        64'd0);
    checkOutput("rstReady",  {63'd0, ready_o},       64'd0);
    checkOutput("rstResult", result_o,               64'd0);
    checkOutput("rstDbz",    {63'd0, div_by_zero_o}, 64'd0);
    checkOutput("rstStall",  {63'd0, stallreq_o},    64'd0);

    // Stall raised combinationally in the issue cycle
    applyStimulus(2'b00, 32'hFFFFFFFD, 32'd5);
    #1;
    checkOutput("issueStall", {63'd0, stallreq_o}, 64'd1);
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 20) checkOutput("calcStall", {63'd0, stallreq_o}, 64'd1);
      if (ready_o) begin
        lat = c;
        break;
      end
    end
    checkOutput("multLat", 64'(lat), 64'd35);
    checkOutput("multRes", result_o, 64'hFFFFFFFF_FFFFFFF1);
    checkOutput("doneStall", {63'd0, stallreq_o}, 64'd0);
    @(negedge clk);
    checkOutput("readyPulse", {63'd0, ready_o}, 64'd0);
    checkOutput("idleBusy",   {63'd0, busy_o},  64'd0);
    checkOutput("resultHold", result_o, 64'hFFFFFFFF_FFFFFFF1);

    // MULTU largest operands
    runOp(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat);
    checkOutput("multuLat", 64'(lat), 64'd35);
    checkOutput("multuRes", result_o, 64'hFFFFFFFE_00000001);

    // DIVU 100/7
    runOp(2'b11, 32'd100, 32'd7, 0, lat);
    checkOutput("divuRes", result_o, {32'd2, 32'd14});
    checkOutput("divuDbz", {63'd0, div_by_zero_o}, 64'd0);

    // DIV -7/2
    runOp(2'b10, 32'hFFFFFFF9, 32'd2, 0, lat);
    checkOutput("divNegRes", result_o, {32'hFFFFFFFF, 32'hFFFFFFFD});

    // DIV MIN_INT / -1 overflow
    runOp(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, lat);
    checkOutput("divOvfRes", result_o, {32'h0, 32'h80000000});
    checkOutput("divOvfDbz", {63'd0, div_by_zero_o}, 64'd0);

    // Divide by zero fast path
    runOp(2'b10, 32'd9, 32'd0, 0, lat);
    checkOutput("dbzLat", 64'(lat), 64'd2);
    checkOutput("dbzRes", result_o, {32'd9, 32'hFFFFFFFF});
    checkOutput("dbzFlag", {63'd0, div_by_zero_o}, 64'd1);
    @(negedge clk);

    // Annul at cycle 10 of a DIVU
    applyStimulus(2'b11, 32'd1000, 32'd3);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 10) annul_i = 1'b1;
    end
    @(negedge clk);
    annul_i = 1'b0;
    checkOutput("annulBusy",   {63'd0, busy_o},        64'd0);
    checkOutput("annulStall",  {63'd0, stallreq_o},    64'd0);
    checkOutput("annulResult", result_o, {32'd9, 32'hFFFFFFFF});
    checkOutput("annulDbzClr", {63'd0, div_by_zero_o}, 64'd0);
    sawReady = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o) sawReady = 1'b1;
    end
    checkOutput("annulNoReady", {63'd0, sawReady}, 64'd0);

    // Start re-raised at cycle 5 must be ignored
    runOp(2'b11, 32'd50, 32'd5, 5, lat);
    checkOutput("ignStartLat", 64'(lat), 64'd35);
    checkOutput("ignStartRes", result_o, {32'd0, 32'd10});
    @(negedge clk);

    // Synchronous reset at cycle 20 of a multiply
    applyStimulus(2'b00, 32'd11, 32'd13);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstBusy",   {63'd0, busy_o},        64'd0);
    checkOutput("midRstReady",  {63'd0, ready_o},       64'd0);
    checkOutput("midRstResult", result_o,               64'd0);
    checkOutput("midRstStall",  {63'd0, stallreq_o},    64'd0);

    // Fresh op after reset
    runOp(2'b01, 32'd6, 32'd7, 0, lat);
    checkOutput("postRstLat", 64'(lat), 64'd35);
    checkOutput("postRstRes", result_o, 64'd42);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
